// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data SRAM responder with byte lanes, per-direction latency and range check
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_mem_read_req_addr,
  input  logic [3:0]  i_mem_read_req_mask,
  input  logic        i_mem_read_req_en,
  input  logic [31:0] i_mem_write_req_addr,
  input  logic [3:0]  i_mem_write_req_mask,
  input  logic [31:0] i_mem_write_req_data,
  input  logic        i_mem_write_req_en,
  output logic [31:0] o_mem_read_rsp_data,
  output logic        o_mem_read_rsp_valid,
  output logic        o_mem_read_rsp_done,
  output logic        o_mem_write_rsp_valid,
  output logic        o_mem_write_rsp_done,
  output logic        o_busy
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];
  localparam logic [7:0]  RD_CNT0 = 8'(READ_LATENCY - 1);
  localparam logic [7:0]  WR_CNT0 = 8'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_WAIT, ST_WR_WAIT, ST_RD_DONE, ST_WR_DONE
  } state_t;

  state_t         r_state, w_state_nx;
  logic [7:0]     r_cnt, w_cnt_nx;
  logic [AW-1:0]  r_idx;
  logic           r_inrng;
  logic [3:0]     r_mask;
  logic [31:0]    r_wdata;
  logic [31:0]    r_mem [DEPTH_WORDS];
  logic [31:0]    r_rd_data;
  logic           r_rd_valid, r_rd_done, r_wr_valid, r_wr_done;

  logic [29:0]    w_sel_word, w_woff;
  logic           w_new_inrng, w_accept;
  logic [AW-1:0]  w_cur_idx;
  logic           w_cur_inrng;
  logic [3:0]     w_cur_mask, w_new_mask;
  logic [31:0]    w_lanes;
  logic           w_unused;

  // Write has priority in IDLE, so the address decode follows the write port whenever it requests.
  assign w_sel_word  = i_mem_write_req_en ? i_mem_write_req_addr[31:2] : i_mem_read_req_addr[31:2];
  assign w_new_mask  = i_mem_write_req_en ? i_mem_write_req_mask : i_mem_read_req_mask;
  assign w_woff      = w_sel_word - BASE_W;
  assign w_new_inrng = (w_woff[29:AW] == '0);
  assign w_accept    = (r_state == ST_IDLE) && (i_mem_write_req_en || i_mem_read_req_en);
  assign w_unused    = ^{i_mem_read_req_addr[1:0], i_mem_write_req_addr[1:0]};

  // A latency of one goes IDLE->DONE directly, so the response must see the request not yet latched.
  assign w_cur_idx   = (r_state == ST_IDLE) ? w_woff[AW-1:0] : r_idx;
  assign w_cur_inrng = (r_state == ST_IDLE) ? w_new_inrng    : r_inrng;
  assign w_cur_mask  = (r_state == ST_IDLE) ? w_new_mask     : r_mask;
  assign w_lanes     = {{8{w_cur_mask[3]}}, {8{w_cur_mask[2]}}, {8{w_cur_mask[1]}}, {8{w_cur_mask[0]}}};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_mem_write_req_en) begin
          w_cnt_nx   = WR_CNT0;
          w_state_nx = (WR_CNT0 == 8'd0) ? ST_WR_DONE : ST_WR_WAIT;
        end else if (i_mem_read_req_en) begin
          w_cnt_nx   = RD_CNT0;
          w_state_nx = (RD_CNT0 == 8'd0) ? ST_RD_DONE : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!i_mem_read_req_en) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = 8'd0;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nx = ST_RD_DONE;
        end
      end
      ST_WR_WAIT: begin
        if (!i_mem_write_req_en) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = 8'd0;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nx = ST_WR_DONE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_idx      <= '0;
      r_inrng    <= 1'b0;
      r_mask     <= 4'd0;
      r_wdata    <= 32'd0;
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
      r_rd_done  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_idx   <= w_woff[AW-1:0];
        r_inrng <= w_new_inrng;
        r_mask  <= w_new_mask;
        r_wdata <= i_mem_write_req_data;
      end
      r_rd_done  <= (w_state_nx == ST_RD_DONE);
      r_rd_valid <= (w_state_nx == ST_RD_DONE) && w_cur_inrng;
      r_rd_data  <= ((w_state_nx == ST_RD_DONE) && w_cur_inrng) ? (r_mem[w_cur_idx] & w_lanes) : 32'd0;
      r_wr_done  <= (w_state_nx == ST_WR_DONE);
      r_wr_valid <= (w_state_nx == ST_WR_DONE) && w_cur_inrng;
    end
  end

  // Array commits on the edge leaving WR_DONE; reset forces IDLE so an interrupted write never lands.
  always_ff @(posedge clk) begin
    if (r_state == ST_WR_DONE && r_inrng) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign o_mem_read_rsp_data   = r_rd_data;
  assign o_mem_read_rsp_valid  = r_rd_valid;
  assign o_mem_read_rsp_done   = r_rd_done;
  assign o_mem_write_rsp_valid = r_wr_valid;
  assign o_mem_write_rsp_done  = r_wr_done;
  assign o_busy                = (r_state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder against an array reference model
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          RL    = 4;
  localparam int          WL    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_rd_addr, i_wr_addr, i_wr_data;
  logic [3:0]  i_rd_mask, i_wr_mask;
  logic        i_rd_en, i_wr_en;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_rd_done, o_wr_valid, o_wr_done, o_busy;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read_req_addr(i_rd_addr), .i_mem_read_req_mask(i_rd_mask), .i_mem_read_req_en(i_rd_en),
    .i_mem_write_req_addr(i_wr_addr), .i_mem_write_req_mask(i_wr_mask),
    .i_mem_write_req_data(i_wr_data), .i_mem_write_req_en(i_wr_en),
    .o_mem_read_rsp_data(o_rd_data), .o_mem_read_rsp_valid(o_rd_valid), .o_mem_read_rsp_done(o_rd_done),
    .o_mem_write_rsp_valid(o_wr_valid), .o_mem_write_rsp_done(o_wr_done),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic valid; logic [31:0] data; } rd_exp_t;
  rd_exp_t     exp_rd[$];
  logic        exp_wr[$];
  rd_exp_t     mon_e;
  logic [31:0] model_mem [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] m);
    if (!in_range(a)) return 32'd0;
    return model_mem[word_of(a)] & lanes(m);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    if (in_range(a))
      model_mem[word_of(a)] = (model_mem[word_of(a)] & ~lanes(m)) | (d & lanes(m));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_done) begin
        if (exp_rd.size() == 0) check("rd_unexpected_done", {31'd0, o_rd_done}, 32'd0);
        else begin
          mon_e = exp_rd.pop_front();
          check("rd_valid", {31'd0, o_rd_valid}, {31'd0, mon_e.valid});
          check("rd_data", o_rd_data, mon_e.data);
        end
      end else begin
        check("rd_idle_valid", {31'd0, o_rd_valid}, 32'd0);
        check("rd_idle_data", o_rd_data, 32'd0);
      end
      if (o_wr_done) begin
        if (exp_wr.size() == 0) check("wr_unexpected_done", {31'd0, o_wr_done}, 32'd0);
        else check("wr_valid", {31'd0, o_wr_valid}, {31'd0, exp_wr.pop_front()});
      end else begin
        check("wr_idle_valid", {31'd0, o_wr_valid}, 32'd0);
      end
    end
  end

  task automatic wait_done(input logic is_wr, input int lat, input string nm);
    int k = 1;
    @(negedge clk);
    while (!(is_wr ? o_wr_done : o_rd_done) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(nm, k, lat);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    exp_wr.push_back(in_range(a));
    model_write(a, m, d);
    i_wr_addr = a; i_wr_mask = m; i_wr_data = d; i_wr_en = 1'b1;
    @(posedge clk);
    wait_done(1'b1, WL, "wr_latency");
    i_wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] m);
    exp_rd.push_back('{valid: in_range(a), data: model_read(a, m)});
    i_rd_addr = a; i_rd_mask = m; i_rd_en = 1'b1;
    @(posedge clk);
    wait_done(1'b0, RL, "rd_latency");
    i_rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int dones;
    rst_n = 1'b0;
    i_rd_addr = '0; i_rd_mask = '0; i_rd_en = 1'b0;
    i_wr_addr = '0; i_wr_mask = '0; i_wr_data = '0; i_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_rd_done", {31'd0, o_rd_done}, 32'd0);
    check("reset_rd_data", o_rd_data, 32'd0);
    check("reset_wr_done", {31'd0, o_wr_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(4 * i), 4'hF, $urandom);

    do_write(32'h0001_0010, 4'hF, 32'hDEAD_BEEF);
    do_read(32'h0001_0010, 4'hF);
    do_write(32'h0001_0010, 4'b0001, 32'h0000_00AA);
    do_read(32'h0001_0010, 4'b0011);

    do_read(32'h0000_0FFC, 4'hF);
    do_read(BASE + 32'(4 * DEPTH), 4'hF);
    do_write(BASE + 32'(4 * DEPTH), 4'hF, 32'hBAD0_BAD0);
    do_write(32'h0000_0FFC, 4'hF, 32'hBAD1_BAD1);
    do_read(BASE, 4'hF);
    do_read(BASE + 32'(4 * (DEPTH - 1)), 4'hF);

    do_write(BASE + 32'h8, 4'b0000, 32'hFFFF_FFFF);
    do_read(BASE + 32'h8, 4'b0000);
    do_read(BASE + 32'h8, 4'hF);

    // Aborted read: en dropped while waiting must yield no done and return to IDLE.
    i_rd_addr = BASE + 32'h4; i_rd_mask = 4'hF; i_rd_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_rd_busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    i_rd_en = 1'b0;
    dones = 0;
    repeat (6) begin @(negedge clk); if (o_rd_done) dones++; end
    check("abort_rd_no_done", dones, 0);
    check("abort_rd_idle", {31'd0, o_busy}, 32'd0);

    // Aborted write must leave the array untouched.
    i_wr_addr = BASE + 32'hC; i_wr_mask = 4'hF; i_wr_data = 32'h5555_AAAA; i_wr_en = 1'b1;
    @(posedge clk); @(negedge clk);
    i_wr_en = 1'b0;
    dones = 0;
    repeat (6) begin @(negedge clk); if (o_wr_done) dones++; end
    check("abort_wr_no_done", dones, 0);
    do_read(BASE + 32'hC, 4'hF);

    // Simultaneous write and read to one address: write first, read sees new data.
    a = BASE + 32'h20;
    exp_wr.push_back(1'b1);
    model_write(a, 4'hF, 32'h1234_5678);
    exp_rd.push_back('{valid: 1'b1, data: model_read(a, 4'hF)});
    i_wr_addr = a; i_wr_mask = 4'hF; i_wr_data = 32'h1234_5678; i_wr_en = 1'b1;
    i_rd_addr = a; i_rd_mask = 4'hF; i_rd_en = 1'b1;
    @(posedge clk);
    wait_done(1'b1, WL, "both_wr_latency");
    i_wr_en = 1'b0;
    wait_done(1'b0, RL + 1, "both_rd_latency");
    i_rd_en = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset during WR_WAIT: outputs clear at once and the write is lost.
    a = BASE + 32'h30;
    i_wr_addr = a; i_wr_mask = 4'hF; i_wr_data = 32'hCAFE_F00D; i_wr_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_pre_busy", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_wr_done", {31'd0, o_wr_done}, 32'd0);
    check("rst_rd_data", o_rd_data, 32'd0);
    i_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(a, 4'hF);

    // Stalled initiator keeps en high: the read is served again.
    a = BASE + 32'h40;
    exp_rd.push_back('{valid: 1'b1, data: model_read(a, 4'hF)});
    exp_rd.push_back('{valid: 1'b1, data: model_read(a, 4'hF)});
    i_rd_addr = a; i_rd_mask = 4'hF; i_rd_en = 1'b1;
    @(posedge clk);
    wait_done(1'b0, RL, "reissue_first");
    wait_done(1'b0, RL + 1, "reissue_second");
    i_rd_en = 1'b0;
    @(posedge clk); @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'(4 * $urandom_range(1, 8));
        1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
        default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1) do_write(a, 4'($urandom), $urandom);
      else do_read(a, 4'($urandom));
    end

    repeat (4) @(negedge clk);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
